// File: rtl/traj_renderer.sv
// traj_renderer: latches the trajectory generator's ball positions, holds them
// for a whole video frame, and answers per-pixel "which ball covers this pixel"
// queries through a fixed 3-stage pipeline.
// Build option: define TRAJ_RENDER_ROUND_EN for a round ball test (dx^2+dy^2 <= R^2).
// Leave it undefined for a square sprite test (|dx|,|dy| <= R).
module traj_renderer #(
   parameter int RADIUS   = 8,
   parameter int GROUND_Y = 700,
   parameter int X_OFFSET = 100
) (
   input  logic        clk_in,
   input  logic        rst_in,
   input  logic [10:0] traj_x_in [7:0],
   input  logic [9:0]  traj_y_in [7:0],
   input  logic        traj_valid_in,
   input  logic [2:0]  num_balls,
   input  logic        new_frame_in,
   input  logic [10:0] hcount_in,
   input  logic [9:0]  vcount_in,
   input  logic        pixel_valid_in,
   output logic        ball_hit_out,
   output logic [2:0]  ball_id_out,
   output logic [7:0]  red_out,
   output logic [7:0]  green_out,
   output logic [7:0]  blue_out,
   output logic        pixel_valid_out
);

   localparam logic signed [12:0] X_OFF_C  = 13'(X_OFFSET);
   localparam logic signed [12:0] GROUND_C = 13'(GROUND_Y);
`ifdef TRAJ_RENDER_ROUND_EN
   localparam logic [24:0]        RAD_SQ_C = 25'(RADIUS * RADIUS);
`else
   localparam logic signed [12:0] RAD_C    = 13'(RADIUS);
`endif

   // Double buffer: shadow catches every strobe, active only changes at frame start.
   logic [10:0]        shadow_x_r [8];
   logic [9:0]         shadow_y_r [8];
   logic               pending_r;
   logic [10:0]        active_x_r [8];
   logic [9:0]         active_y_r [8];
   logic [2:0]         num_lat_r;
   // Set by the first real swap; a cleared active buffer would otherwise draw
   // balls at the origin once num_balls is re-latched.
   logic               loaded_r;

   // Pipeline state.
   logic signed [12:0] dx_s [8];
   logic signed [12:0] dy_s [8];
   logic [7:0]         en_s;
   logic signed [12:0] dx_r [8];
   logic signed [12:0] dy_r [8];
   logic [7:0]         en_r;
   logic               v1_r;
   logic [7:0]         hit_s;
   logic [7:0]         hit_r;
   logic               v2_r;
   logic [2:0]         id_s;
   logic               any_s;
`ifdef TRAJ_RENDER_ROUND_EN
   logic [11:0]        mag_x_s [8];
   logic [11:0]        mag_y_s [8];
   logic [23:0]        sq_x_s  [8];
   logic [23:0]        sq_y_s  [8];
   logic [24:0]        sum_s   [8];
`endif

   // Capture strobes into shadow and swap into active at frame start; the swap
   // reads pre-edge shadow, so a coincident strobe lands for the next frame.
   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         for (int i = 0; i < 8; i++) begin
            shadow_x_r[i] <= 11'd0;
            shadow_y_r[i] <= 10'd0;
            active_x_r[i] <= 11'd0;
            active_y_r[i] <= 10'd0;
         end
         pending_r <= 1'b0;
         num_lat_r <= 3'd0;
         loaded_r  <= 1'b0;
      end else begin
         if (new_frame_in) begin
            num_lat_r <= num_balls;
            if (pending_r) begin
               for (int i = 0; i < 8; i++) begin
                  active_x_r[i] <= shadow_x_r[i];
                  active_y_r[i] <= shadow_y_r[i];
               end
               loaded_r  <= 1'b1;
               pending_r <= 1'b0;
            end
         end
         if (traj_valid_in) begin
            for (int i = 0; i < 8; i++) begin
               shadow_x_r[i] <= traj_x_in[i];
               shadow_y_r[i] <= traj_y_in[i];
            end
            pending_r <= 1'b1;
         end
      end
   end

   // S1 arithmetic: signed offsets from each ball centre plus a per-ball enable snapshot.
   always_comb begin
      for (int i = 0; i < 8; i++) begin
         dx_s[i] = $signed({2'b00, hcount_in}) - ($signed({2'b00, active_x_r[i]}) + X_OFF_C);
         dy_s[i] = $signed({3'b000, vcount_in}) - (GROUND_C - $signed({3'b000, active_y_r[i]}));
         en_s[i] = loaded_r && (4'(i) < {1'b0, num_lat_r});
      end
   end

   // S1 registers.
   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         for (int i = 0; i < 8; i++) begin
            dx_r[i] <= 13'sd0;
            dy_r[i] <= 13'sd0;
         end
         en_r <= 8'd0;
         v1_r <= 1'b0;
      end else begin
         dx_r <= dx_s;
         dy_r <= dy_s;
         en_r <= en_s;
         v1_r <= pixel_valid_in;
      end
   end

`ifdef TRAJ_RENDER_ROUND_EN
   // S2 inside-test, round ball: squared magnitudes compared against radius squared.
   always_comb begin
      for (int i = 0; i < 8; i++) begin
         mag_x_s[i] = 12'(dx_r[i][12] ? -dx_r[i] : dx_r[i]);
         mag_y_s[i] = 12'(dy_r[i][12] ? -dy_r[i] : dy_r[i]);
         sq_x_s[i]  = 24'(mag_x_s[i]) * 24'(mag_x_s[i]);
         sq_y_s[i]  = 24'(mag_y_s[i]) * 24'(mag_y_s[i]);
         sum_s[i]   = 25'(sq_x_s[i]) + 25'(sq_y_s[i]);
         hit_s[i]   = en_r[i] && (sum_s[i] <= RAD_SQ_C);
      end
   end
`else
   // S2 inside-test, square sprite: signed window compare on both axes.
   always_comb begin
      for (int i = 0; i < 8; i++) begin
         hit_s[i] = en_r[i] &&
                    (dx_r[i] >= -RAD_C) && (dx_r[i] <= RAD_C) &&
                    (dy_r[i] >= -RAD_C) && (dy_r[i] <= RAD_C);
      end
   end
`endif

   // S2 registers.
   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         hit_r <= 8'd0;
         v2_r  <= 1'b0;
      end else begin
         hit_r <= hit_s;
         v2_r  <= v1_r;
      end
   end

   // S3 priority encoder: scanning downward leaves the lowest hitting index.
   always_comb begin
      id_s  = 3'd0;
      any_s = 1'b0;
      for (int i = 7; i >= 0; i--) begin
         id_s  = hit_r[i] ? 3'(i) : id_s;
         any_s = any_s | hit_r[i];
      end
   end

   // S3 output registers: colour from ID bits; invalid pixels force everything to zero.
   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         ball_hit_out    <= 1'b0;
         ball_id_out     <= 3'd0;
         red_out         <= 8'd0;
         green_out       <= 8'd0;
         blue_out        <= 8'd0;
         pixel_valid_out <= 1'b0;
      end else begin
         pixel_valid_out <= v2_r;
         if (v2_r && any_s) begin
            ball_hit_out <= 1'b1;
            ball_id_out  <= id_s;
            red_out      <= id_s[0] ? 8'hFF : 8'h40;
            green_out    <= id_s[1] ? 8'hFF : 8'h40;
            blue_out     <= id_s[2] ? 8'hFF : 8'h40;
         end else begin
            ball_hit_out <= 1'b0;
            ball_id_out  <= 3'd0;
            red_out      <= 8'd0;
            green_out    <= 8'd0;
            blue_out     <= 8'd0;
         end
      end
   end

endmodule

// File: tb/tb_traj_renderer.sv
// Directed testbench for traj_renderer with a scoreboard queue of expected pixels.
module tb_traj_renderer;

   typedef struct packed {
      logic       hit;
      logic [2:0] id;
      logic [7:0] r;
      logic [7:0] g;
      logic [7:0] b;
      logic       v;
   } exp_t;

   logic        clk;
   logic        rst;
   logic [10:0] tx [7:0];
   logic [9:0]  ty [7:0];
   logic        tvl;
   logic [2:0]  nb;
   logic        nf;
   logic [10:0] hc;
   logic [9:0]  vc;
   logic        pv;
   logic        hit_o;
   logic [2:0]  id_o;
   logic [7:0]  r_o, g_o, b_o;
   logic        pv_o;

   int n_checks = 0;
   int n_fail   = 0;

   exp_t  exp_q [$];
   string tag_q [$];

   // Bench-side model of the buffer state
   int m_sx [8], m_sy [8], m_ax [8], m_ay [8];
   bit m_pend, m_loaded;
   int m_num;

   traj_renderer dut (
      .clk_in(clk), .rst_in(rst),
      .traj_x_in(tx), .traj_y_in(ty), .traj_valid_in(tvl),
      .num_balls(nb), .new_frame_in(nf),
      .hcount_in(hc), .vcount_in(vc), .pixel_valid_in(pv),
      .ball_hit_out(hit_o), .ball_id_out(id_o),
      .red_out(r_o), .green_out(g_o), .blue_out(b_o),
      .pixel_valid_out(pv_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic exp_t model_px(input int h, input int v, input bit valid);
      exp_t e;
      bit   found;
      int   dx, dy;
      e = '0;
      found = 1'b0;
      e.v = valid;
      if (valid) begin
         for (int i = 0; i < 8; i++) begin
            dx = h - (m_ax[i] + 100);
            dy = v - (700 - m_ay[i]);
            if (!found && m_loaded && i < m_num &&
`ifdef TRAJ_RENDER_ROUND_EN
                (dx * dx + dy * dy <= 64)
`else
                (dx >= -8 && dx <= 8 && dy >= -8 && dy <= 8)
`endif
               ) begin
               found = 1'b1;
               e.hit = 1'b1;
               e.id  = 3'(i);
               e.r   = e.id[0] ? 8'hFF : 8'h40;
               e.g   = e.id[1] ? 8'hFF : 8'h40;
               e.b   = e.id[2] ? 8'hFF : 8'h40;
            end
         end
      end
      return e;
   endfunction

   // One cycle: check the output due now, drive a pixel, queue its expectation.
   task automatic step(input string tag, input int h, input int v, input bit valid,
                       input bit strobe = 1'b0, input bit frame = 1'b0);
      exp_t  e;
      exp_t  obs;
      string t;
      @(negedge clk);
      if (exp_q.size() == 3) begin
         e   = exp_q.pop_front();
         t   = tag_q.pop_front();
         obs = {hit_o, id_o, r_o, g_o, b_o, pv_o};
         n_checks++;
         assert (obs === e) else begin
            n_fail++;
            $error("FAIL %s: observed hit/id/rgb/valid=%h expected %h", t, obs, e);
         end
      end
      rst = 1'b0;
      hc  = 11'(h);
      vc  = 10'(v);
      pv  = valid;
      tvl = strobe;
      nf  = frame;
      exp_q.push_back(model_px(h, v, valid));
      tag_q.push_back(tag);
      if (frame) begin
         m_num = int'(nb);
         if (m_pend) begin
            m_ax = m_sx;
            m_ay = m_sy;
            m_loaded = 1'b1;
            m_pend = 1'b0;
         end
      end
      if (strobe) begin
         for (int i = 0; i < 8; i++) begin
            m_sx[i] = int'(tx[i]);
            m_sy[i] = int'(ty[i]);
         end
         m_pend = 1'b1;
      end
   endtask

   task automatic do_reset();
      logic [28:0] obs;
      @(negedge clk);
      rst = 1'b1;
      pv  = 1'b0;
      tvl = 1'b0;
      nf  = 1'b0;
      @(negedge clk);
      obs = {hit_o, id_o, r_o, g_o, b_o, pv_o};
      n_checks++;
      assert (obs === 29'd0) else begin
         n_fail++;
         $error("FAIL reset_outputs: observed %h expected %h", obs, 29'd0);
      end
      for (int i = 0; i < 8; i++) begin
         m_sx[i] = 0; m_sy[i] = 0; m_ax[i] = 0; m_ay[i] = 0;
      end
      m_pend = 1'b0; m_loaded = 1'b0; m_num = 0;
      exp_q.delete();
      tag_q.delete();
      for (int i = 0; i < 3; i++) begin
         exp_q.push_back('0);
         tag_q.push_back("post_reset");
      end
   endtask

   task automatic set_ball(input int idx, input int x, input int y);
      tx[idx] = 11'(x);
      ty[idx] = 10'(y);
   endtask

   initial begin
      rst = 1'b1; tvl = 1'b0; nf = 1'b0; pv = 1'b0;
      hc = 11'd0; vc = 10'd0; nb = 3'd0;
      for (int i = 0; i < 8; i++) begin
         tx[i] = 11'd0;
         ty[i] = 10'd0;
      end
      do_reset();

      // Reset then sweep: no strobe ever, so nothing is drawn even with num_balls=3.
      nb = 3'd3;
      step("sweep_frame", 0, 0, 1'b0, 1'b0, 1'b1);
      for (int r = 0; r < 6; r++) begin
         for (int h = 0; h < 1280; h += 64) step("sweep_empty", h, r * 140, 1'b1);
         step("sweep_origin", 100, 700 - 4 + r, 1'b1);
      end

      // Single ball 0 at (200,100) -> centre (300,600).
      for (int i = 0; i < 8; i++) set_ball(i, 0, 1000);
      set_ball(0, 200, 100);
      nb = 3'd1;
      step("single_strobe", 0, 0, 1'b0, 1'b1, 1'b0);
      step("single_frame", 0, 0, 1'b0, 1'b0, 1'b1);
      step("single_hit", 308, 600, 1'b1);
      step("single_miss_x", 317, 600, 1'b1);
      step("single_diag", 314, 606, 1'b1);
      step("single_corner", 292, 592, 1'b1);
      step("single_edge_out", 291, 600, 1'b1);
      step("single_invalid", 300, 600, 1'b0);
      step("single_centre", 300, 600, 1'b1);

      // Overlap: balls 2 and 5 coincide at centre (600,400).
      for (int i = 0; i < 8; i++) set_ball(i, 0, 1000);
      set_ball(2, 500, 300);
      set_ball(5, 500, 300);
      nb = 3'd6;
      step("ovl_strobe", 0, 0, 1'b0, 1'b1, 1'b0);
      step("ovl_frame", 0, 0, 1'b0, 1'b0, 1'b1);
      step("ovl_nb6", 600, 400, 1'b1);
      nb = 3'd3;
      step("ovl_frame3", 0, 0, 1'b0, 1'b0, 1'b1);
      step("ovl_nb3", 603, 397, 1'b1);
      nb = 3'd2;
      step("ovl_frame2", 0, 0, 1'b0, 1'b0, 1'b1);
      step("ovl_nb2_excl", 600, 400, 1'b1);

      // Frame atomicity: A at (300,600), B at (500,600), C at (700,600).
      for (int i = 0; i < 8; i++) set_ball(i, 0, 1000);
      nb = 3'd1;
      set_ball(0, 200, 100);
      step("atom_strobeA", 0, 0, 1'b0, 1'b1, 1'b0);
      step("atom_frameA", 0, 0, 1'b0, 1'b0, 1'b1);
      step("atom_A_shown", 300, 600, 1'b1);
      set_ball(0, 400, 100);
      step("atom_strobeB", 300, 600, 1'b1, 1'b1, 1'b0);
      step("atom_A_held", 300, 600, 1'b1);
      step("atom_B_hidden", 500, 600, 1'b1);
      step("atom_frameB", 500, 600, 1'b1, 1'b0, 1'b1);
      step("atom_B_shown", 500, 600, 1'b1);
      step("atom_A_gone", 300, 600, 1'b1);
      set_ball(0, 600, 100);
      step("atom_strobeC_frame", 500, 600, 1'b1, 1'b1, 1'b1);
      step("atom_B_kept", 500, 600, 1'b1);
      step("atom_C_hidden", 700, 600, 1'b1);
      step("atom_frameC", 0, 0, 1'b0, 1'b0, 1'b1);
      step("atom_C_shown", 700, 600, 1'b1);
      step("atom_B_gone", 500, 600, 1'b1);

      // Off-screen: traj_y=800 puts the centre at row -100.
      set_ball(0, 200, 800);
      step("off_strobe", 0, 0, 1'b0, 1'b1, 1'b0);
      step("off_frame", 0, 0, 1'b0, 1'b0, 1'b1);
      for (int v = 0; v < 768; v += 8) step("off_rows", 300, v, 1'b1);
      step("off_row0", 300, 0, 1'b1);

      // Mid-frame reset: visible ball, pending update, then reset discards everything.
      set_ball(0, 200, 100);
      step("mid_strobe", 0, 0, 1'b0, 1'b1, 1'b0);
      step("mid_frame", 0, 0, 1'b0, 1'b0, 1'b1);
      step("mid_hit", 300, 600, 1'b1);
      step("mid_pending", 300, 600, 1'b1, 1'b1, 1'b0);
      step("mid_hit2", 300, 600, 1'b1);
      do_reset();
      step("post_rst_px", 300, 600, 1'b1);
      step("post_rst_frame", 300, 600, 1'b1, 1'b0, 1'b1);
      step("post_rst_px2", 300, 600, 1'b1);
      step("post_rst_px3", 300, 600, 1'b1);

      // Flush the pipeline so every queued expectation is compared.
      for (int i = 0; i < 4; i++) step("flush", 0, 0, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
